// File: rtl/cordic_vectoring_if.sv
// Sample-in / result-out bundle for the iterative vectoring CORDIC.
// The slave side is the CORDIC itself; the master side feeds vectors and consumes results.
interface cordic_vectoring_if #(
  parameter int N_FRAC = 7
);
  logic signed [N_FRAC:0]   x_i;
  logic signed [N_FRAC:0]   y_i;
  logic                     data_in_valid_strobe_i;
  logic                     ready_o;
  logic signed [N_FRAC+2:0] mag_o;
  logic signed [N_FRAC:0]   z_o;
  logic                     data_out_valid_strobe_o;

  modport slave (
    input  x_i, y_i, data_in_valid_strobe_i,
    output ready_o, mag_o, z_o, data_out_valid_strobe_o
  );

  modport master (
    output x_i, y_i, data_in_valid_strobe_i,
    input  ready_o, mag_o, z_o, data_out_valid_strobe_o
  );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: rotates (x,y) onto the +x axis, returning the scaled
// magnitude and atan2(y,x) in units of pi/2^N_FRAC. One vector every N_FRAC+2 cycles.
//
// state | meaning
// IDLE  | ready for a new vector; load with quadrant pre-fold on strobe
// ITER  | one micro-rotation per cycle, i = cnt_q = 0..N_FRAC-1
// DONE  | register results and pulse the output strobe
module cordic_vectoring #(
  parameter int N_FRAC = 7
) (
  input logic                clk_i,
  input logic                rst_i,
  cordic_vectoring_if.slave  bus
);
  localparam int W  = N_FRAC + 3;
  localparam int ZW = N_FRAC + 2;
  localparam int CW = $clog2(N_FRAC + 1);
  localparam logic [CW-1:0]        LAST  = CW'(N_FRAC - 1);
  localparam logic signed [ZW-1:0] Z_QTR = ZW'(2 ** (N_FRAC - 1));

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t state_q, state_d;

  logic signed [W-1:0]      x_q, y_q;
  logic signed [ZW-1:0]     z_q;
  logic [CW-1:0]            cnt_q;
  logic signed [W-1:0]      mag_q;
  logic signed [N_FRAC:0]   zo_q;
  logic                     vld_q;

  logic signed [W-1:0]      x_ext, y_ext, x_sh, y_sh;
  logic signed [ZW-1:0]     atan_i;

  function automatic logic signed [ZW-1:0] atan_lut(input logic [CW-1:0] i);
    case (int'(i))
      0:       atan_lut = ZW'(32);
      1:       atan_lut = ZW'(19);
      2:       atan_lut = ZW'(10);
      3:       atan_lut = ZW'(5);
      4:       atan_lut = ZW'(3);
      5:       atan_lut = ZW'(1);
      6:       atan_lut = ZW'(1);
      default: atan_lut = '0;
    endcase
  endfunction

  // Two guard bits: negating -2^N_FRAC during the fold must not overflow.
  assign x_ext  = {{2{bus.x_i[N_FRAC]}}, bus.x_i};
  assign y_ext  = {{2{bus.y_i[N_FRAC]}}, bus.y_i};
  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign atan_i = atan_lut(cnt_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.data_in_valid_strobe_i) state_d = ITER;
      ITER:    if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      cnt_q <= '0;
      mag_q <= '0;
      zo_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.data_in_valid_strobe_i) begin
            cnt_q <= '0;
            // Fold left half-plane into the right so the iterations converge.
            if (bus.x_i < 0 && bus.y_i >= 0) begin
              x_q <= y_ext;
              y_q <= -x_ext;
              z_q <= Z_QTR;
            end else if (bus.x_i < 0) begin
              x_q <= -y_ext;
              y_q <= x_ext;
              z_q <= -Z_QTR;
            end else begin
              x_q <= x_ext;
              y_q <= y_ext;
              z_q <= '0;
            end
          end
        end
        ITER: begin
          if (y_q >= 0) begin
            x_q <= x_q + y_sh;
            y_q <= y_q - x_sh;
            z_q <= z_q + atan_i;
          end else begin
            x_q <= x_q - y_sh;
            y_q <= y_q + x_sh;
            z_q <= z_q - atan_i;
          end
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          mag_q <= x_q;
          zo_q  <= z_q[N_FRAC:0];
          vld_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o                 = (state_q == IDLE);
  assign bus.mag_o                   = mag_q;
  assign bus.z_o                     = zo_q;
  assign bus.data_out_valid_strobe_o = vld_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed and random checks of cordic_vectoring against an integer reference model
// of the vectoring algorithm, plus latency, reset-abort and strobe-handling checks.
module tb_cordic_vectoring;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   tests = 0;
  int   fails = 0;

  cordic_vectoring_if #(.N_FRAC(7)) dut_if ();
  cordic_vectoring #(.N_FRAC(7)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(dut_if));

  always #5 clk_i = ~clk_i;

  function automatic void model(input int xi, input int yi, output int mag, output int z);
    int atan_tab[7] = '{32, 19, 10, 5, 3, 1, 1};
    int x, y, zz, xs, ys;
    if (xi < 0 && yi >= 0)  begin x = yi;  y = -xi; zz = 64;  end
    else if (xi < 0)        begin x = -yi; y = xi;  zz = -64; end
    else                    begin x = xi;  y = yi;  zz = 0;   end
    for (int i = 0; i < 7; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (y >= 0) begin x = x + ys; y = y - xs; zz = zz + atan_tab[i]; end
      else        begin x = x - ys; y = y + xs; zz = zz - atan_tab[i]; end
    end
    mag = x;
    z   = ((zz + 128) % 256 + 256) % 256 - 128;
  endfunction

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = (obs > exp) ? obs - exp : exp - obs;
    tests++;
    assert ((d <= tol) === 1'b1) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d +- %0d", tag, obs, exp, tol);
    end
  endtask

  // Launches one vector and waits for its result; lat = edges after the sampling edge.
  task automatic run_vector(input int xv, input int yv, output int mag, output int z,
                            output int lat, output logic busy_k1);
    int w;
    w = 0;
    while (dut_if.ready_o !== 1'b1 && w < 40) begin @(posedge clk_i); #1; w++; end
    @(negedge clk_i);
    dut_if.x_i = 8'(xv);
    dut_if.y_i = 8'(yv);
    dut_if.data_in_valid_strobe_i = 1'b1;
    @(posedge clk_i);
    #1 dut_if.data_in_valid_strobe_i = 1'b0;
    lat = -1;
    busy_k1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_i); #1;
      if (k == 1) busy_k1 = ~dut_if.ready_o;
      if (dut_if.data_out_valid_strobe_o === 1'b1) begin lat = k; break; end
    end
    mag = int'(dut_if.mag_o);
    z   = int'(dut_if.z_o);
  endtask

  task automatic check_vec(input string tag, input int xv, input int yv,
                           output int mag, output int z);
    int em, ez, lat, mag2, z2;
    logic busy;
    model(xv, yv, em, ez);
    run_vector(xv, yv, mag, z, lat, busy);
    check_int({tag, " latency"}, lat, 8);
    check_int({tag, " mag"}, mag, em);
    check_int({tag, " z"}, z, ez);
    check_int({tag, " ready_with_strobe"}, int'(dut_if.ready_o), 1);
    check_int({tag, " busy_in_iter"}, int'(busy), 1);
    @(posedge clk_i); #1;
    check_int({tag, " strobe_one_cycle"}, int'(dut_if.data_out_valid_strobe_o), 0);
    repeat (3) @(posedge clk_i);
    #1;
    mag2 = int'(dut_if.mag_o);
    z2   = int'(dut_if.z_o);
    check_int({tag, " mag_hold"}, mag2, mag);
    check_int({tag, " z_hold"}, z2, z);
  endtask

  initial begin
    int mag, z, em, ez, cnt, lat, gm, gz, xa, ya, xb, yb;
    logic busy;
    dut_if.x_i = '0;
    dut_if.y_i = '0;
    dut_if.data_in_valid_strobe_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_int("rst mag", int'(dut_if.mag_o), 0);
    check_int("rst z", int'(dut_if.z_o), 0);
    check_int("rst strobe", int'(dut_if.data_out_valid_strobe_o), 0);
    @(negedge clk_i) rst_i = 1'b1;
    #1 check_int("rst ready", int'(dut_if.ready_o), 1);

    // Directed corner vectors, both exact and against the nominal geometry.
    check_vec("v64_0", 64, 0, mag, z);
    check_near("v64_0 mag_nom", mag, 105, 2);
    check_near("v64_0 z_nom", z, 0, 1);
    check_vec("v0_64", 0, 64, mag, z);
    check_near("v0_64 mag_nom", mag, 105, 2);
    check_near("v0_64 z_nom", z, 64, 2);
    check_vec("v0_m64", 0, -64, mag, z);
    check_near("v0_m64 z_nom", z, -64, 2);
    check_vec("vm128_0", -128, 0, mag, z);
    check_near("vm128_0 mag_nom", mag, 211, 3);
    check_int("vm128_0 z_pi_wrap", int'(z inside {126, 127, -128, -127}), 1);
    check_vec("vm64_m64", -64, -64, mag, z);
    check_near("vm64_m64 z_nom", z, -96, 2);
    check_vec("v127_m128", 127, -128, mag, z);

    // A strobe while iterating must be dropped.
    xa = 50; ya = -20;
    model(xa, ya, em, ez);
    @(negedge clk_i);
    dut_if.x_i = 8'(xa); dut_if.y_i = 8'(ya);
    dut_if.data_in_valid_strobe_i = 1'b1;
    @(posedge clk_i); #1 dut_if.data_in_valid_strobe_i = 1'b0;
    cnt = 0; gm = 0; gz = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) begin
        dut_if.x_i = 8'(-100); dut_if.y_i = 8'(90);
        dut_if.data_in_valid_strobe_i = 1'b1;
      end
      @(posedge clk_i); #1;
      dut_if.data_in_valid_strobe_i = 1'b0;
      if (dut_if.data_out_valid_strobe_o === 1'b1) begin
        cnt++; gm = int'(dut_if.mag_o); gz = int'(dut_if.z_o);
      end
    end
    check_int("ignore_busy strobes", cnt, 1);
    check_int("ignore_busy mag", gm, em);
    check_int("ignore_busy z", gz, ez);

    // Reset in the middle of iterating aborts the vector.
    @(negedge clk_i);
    dut_if.x_i = 8'(30); dut_if.y_i = 8'(40);
    dut_if.data_in_valid_strobe_i = 1'b1;
    @(posedge clk_i); #1 dut_if.data_in_valid_strobe_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    check_int("abort mag", int'(dut_if.mag_o), 0);
    check_int("abort z", int'(dut_if.z_o), 0);
    check_int("abort strobe", int'(dut_if.data_out_valid_strobe_o), 0);
    @(negedge clk_i) rst_i = 1'b1;
    #1 check_int("abort ready", int'(dut_if.ready_o), 1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_i); #1;
      if (dut_if.data_out_valid_strobe_o === 1'b1) cnt++;
    end
    check_int("abort no_strobe", cnt, 0);
    check_vec("after_abort", 30, 40, mag, z);

    // Second vector offered on the output-strobe cycle of the first.
    xa = 100; ya = 33; xb = -7; yb = 120;
    run_vector(xa, ya, gm, gz, lat, busy);
    model(xa, ya, em, ez);
    check_int("b2b first_mag", gm, em);
    dut_if.x_i = 8'(xb); dut_if.y_i = 8'(yb);
    dut_if.data_in_valid_strobe_i = 1'b1;
    @(posedge clk_i); #1 dut_if.data_in_valid_strobe_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (dut_if.data_out_valid_strobe_o === 1'b1) begin lat = k; break; end
      @(posedge clk_i); #1;
    end
    model(xb, yb, em, ez);
    check_int("b2b spacing", lat, 9);
    check_int("b2b second_mag", int'(dut_if.mag_o), em);
    check_int("b2b second_z", int'(dut_if.z_o), ez);

    for (int n = 0; n < 40; n++) begin
      xa = int'($urandom_range(255)) - 128;
      ya = int'($urandom_range(255)) - 128;
      model(xa, ya, em, ez);
      run_vector(xa, ya, gm, gz, lat, busy);
      check_int("rand latency", lat, 8);
      check_int("rand mag", gm, em);
      check_int("rand z", gz, ez);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cordic_vectoring.md
CORDIC_VECTORING -- requirements
Module: cordic_vectoring

Interface
REQ-001 SHALL have parameter N_FRAC, default 7, meaning fractional bits of the signed Q0.N_FRAC samples; angle scale 2^N_FRAC = pi.
REQ-002 SHALL have port clk_i  input  1  rising-edge clock.
REQ-003 SHALL have port rst_i  input  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
REQ-004 SHALL have port x_i  input  N_FRAC+1  signed input vector x component.
REQ-005 SHALL have port y_i  input  N_FRAC+1  signed input vector y component.
REQ-006 SHALL have port data_in_valid_strobe_i  input  1  one-cycle strobe marking x_i/y_i valid.
REQ-007 SHALL have port ready_o  output  1  high while a new vector can be accepted.
REQ-008 SHALL have port mag_o  output  N_FRAC+3  signed magnitude, CORDIC gain (~1.647) not removed.
REQ-009 SHALL have port z_o  output  N_FRAC+1  signed angle atan2(y,x), 64 = +pi/2, -128 = -pi.
REQ-010 SHALL have port data_out_valid_strobe_o  output  1  one-cycle strobe marking mag_o/z_o valid.

Function
REQ-011 SHALL be an iterative vectoring CORDIC (inverse direction of the rotation pipeline): drives y to 0, accumulates angle in z.
REQ-012 SHALL implement states IDLE, ITER, DONE; reset state IDLE.
REQ-013 SHALL assert ready_o only in IDLE.
REQ-014 SHALL, in IDLE with data_in_valid_strobe_i=1, load operands, clear iteration counter to 0, go to ITER; strobes outside IDLE SHALL be ignored (no queueing).
REQ-015 SHALL pre-fold on load: x_i<0 and y_i>=0 -> x=y_i, y=-x_i, z=+64; x_i<0 and y_i<0 -> x=-y_i, y=x_i, z=-64; else x=x_i, y=y_i, z=0.
REQ-016 SHALL hold x, y sign-extended to N_FRAC+3 bits and z to N_FRAC+2 bits internally; negation of -128 SHALL yield +128 without overflow.
REQ-017 SHALL perform one micro-rotation per ITER cycle, i = counter: if y>=0 then x+=y>>>i, y-=x>>>i, z+=atan_i, else x-=y>>>i, y+=x>>>i, z-=atan_i, using pre-update x,y and arithmetic shifts.
REQ-018 SHALL use atan table (units pi/128) for i=0..6: 32, 19, 10, 5, 3, 1, 1.
REQ-019 SHALL execute exactly N_FRAC iterations (i=0..6), then go to DONE.
REQ-020 SHALL, in DONE, register mag_o=x, z_o=z[N_FRAC:0] (modulo-2pi wrap, +128 -> -128), pulse data_out_valid_strobe_o for exactly one cycle, return to IDLE.
REQ-021 SHALL give latency: strobe sampled at edge E0 -> data_out_valid_strobe_o high in the cycle after edge E0+8; ready_o high again same cycle as output strobe.
REQ-022 SHALL hold mag_o and z_o stable between output strobes.
REQ-023 SHALL accept a new strobe in the same cycle the output strobe is high (back-to-back throughput one vector per 9 cycles).

Reset
REQ-024 SHALL, while rst_i=0, asynchronously force state IDLE, counter 0, internal x/y/z 0, mag_o=0, z_o=0, data_out_valid_strobe_o=0, ready_o=1 after release.
REQ-025 SHALL abort any in-flight computation on reset with no output strobe afterwards for that operand.

Verification
REQ-026 SHALL cover x=64,y=0 -> mag_o 105+-2, z_o 0+-1, strobe 8 cycles after input.
REQ-027 SHALL cover x=0,y=64 -> mag_o 105+-2, z_o 64+-2; and x=0,y=-64 -> z_o -64+-2.
REQ-028 SHALL cover x=-128,y=0 -> mag_o 211+-3, z_o in {126,127,-128,-127} (pi wrap); x=-64,y=-64 -> z_o -96+-2.
REQ-029 SHALL cover strobe asserted during ITER -> ignored, exactly one output strobe, result of first vector.
REQ-030 SHALL cover rst_i low at iteration 3 -> outputs 0 immediately, no strobe; next vector after release correct.
REQ-031 SHALL cover back-to-back input on output-strobe cycle -> second result strobe exactly 9 cycles later.
